seq_divider_32: RTL and testbench

- Iterative restoring divider; the inverse operation of the combinational multiplier tree.
- Serves RV32M DIV/DIVU/REM/REMU in the execute stage. The pipeline stalls on busy.
- One quotient bit per cycle with a fixed, data-independent latency.
- Quotient and remainder are produced together, with RISC-V divide-by-zero and overflow semantics.

---
 rtl/seq_divider_32.sv | 108 ++++++++++
 tb/tb_seq_divider_32.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Iterative restoring divider: one quotient bit per cycle, fixed latency.
// Produces quotient and remainder with RISC-V signed, overflow and divide-by-zero rules.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
  logic             neg_q, neg_r, div0;
  logic [WIDTH:0]   shifted, diff;

  // Trial subtraction: rem < dvs always holds, so the shifted value fits in WIDTH+1 bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = CALC;
      end
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state, including the datapath registers, is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      dvd_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      // done trails the DONE state by one edge; busy covers the whole operation including it.
      done <= (state == DONE);
      busy <= accept | (busy & ~done);
      case (state)
        IDLE: if (accept) begin
          quo     <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs     <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
          dvd_raw <= dividend;
          neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r   <= is_signed & dividend[WIDTH-1];
          div0    <= (divisor == '0);
          rem     <= '0;
          cnt     <= CW'(WIDTH - 1);
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (div0) begin
            quotient  <= '1;
            remainder <= dvd_raw;
          end else begin
            quotient  <= neg_q ? -quo : quo;
            remainder <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed-vector bench for seq_divider_32: latency, sign rules, div0, overflow, protocol, reset.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Launch one operation from IDLE and observe it; returns done latency, busy-low samples, post-done state.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output int busy_low, output logic [31:0] q,
                        output logic [31:0] r, output logic post_busy);
    start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_low = 0;
    for (int n = 1; n <= 100; n++) begin
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        lat = n - 1;
        break;
      end
      @(posedge clk); #1;
    end
    q = quotient; r = remainder;
    @(posedge clk); #1;
    post_busy = busy;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er);
    int lat, bl; logic [31:0] q, r; logic pb;
    run_op(a, b, sgn, lat, bl, q, r, pb);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL %s latency: got %0d want 34", name, lat); end
    total++;
    if (q !== eq) begin bad++; $display("FAIL %s quotient: got %h want %h", name, q, eq); end
    total++;
    if (r !== er) begin bad++; $display("FAIL %s remainder: got %h want %h", name, r, er); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      bad++; $display("FAIL reset outputs: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat, bl; logic [31:0] q, r; logic pb;
    run_op(32'd100, 32'd7, 1'b0, lat, bl, q, r, pb);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL divu latency: got %0d want 34", lat); end
    total++;
    if (bl !== 0) begin bad++; $display("FAIL divu busy: got %0d low samples want 0", bl); end
    total++;
    if (q !== 32'd14 || r !== 32'd2) begin bad++; $display("FAIL divu 100/7: got q=%0d r=%0d want 14 2", q, r); end
    total++;
    if (pb !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL divu after done: got busy=%b done=%b want 0 0", pb, done); end
  endtask

  task automatic test_signed;
    check_op("div -7/2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    check_op("div 7/-2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1);
    check_op("div -20/5", 32'hFFFF_FFEC, 32'h5, 1'b1, 32'hFFFF_FFFC, 32'h0);
  endtask

  task automatic test_div0;
    check_op("divu by 0", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
    check_op("div by 0", 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
    check_op("div -5 by 0", 32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
  endtask

  task automatic test_overflow;
    check_op("div overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
    check_op("divu same ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
  endtask

  task automatic test_ignore_start;
    int lat;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 10) begin start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b1; end
      if (n == 11) start = 1'b0;
      if (done === 1'b1) begin lat = n - 1; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (lat !== 34) begin bad++; $display("FAIL ignore latency: got %0d want 34", lat); end
    total++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++; $display("FAIL ignore result: got q=%0d r=%0d want 14 2", quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int d1, d2; logic [31:0] q1, r1;
    d1 = -1; d2 = -1; q1 = '0; r1 = '0;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    dividend = 32'hFFFF_FFFF; divisor = 32'h10;
    for (int n = 1; n <= 90; n++) begin
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = n - 1; q1 = quotient; r1 = remainder; end
        else begin d2 = n - 1; start = 1'b0; break; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (d1 !== 34) begin bad++; $display("FAIL b2b first done: got %0d want 34", d1); end
    total++;
    if (d2 - d1 !== 35) begin bad++; $display("FAIL b2b spacing: got %0d want 35", d2 - d1); end
    total++;
    if (q1 !== 32'd14 || r1 !== 32'd2) begin bad++; $display("FAIL b2b first result: got q=%h r=%h want e 2", q1, r1); end
    total++;
    if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin
      bad++; $display("FAIL b2b second result: got q=%h r=%h want 0fffffff f", quotient, remainder);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b idle after release: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int spurious;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      bad++; $display("FAIL mid reset outputs: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    total++;
    if (spurious !== 0) begin bad++; $display("FAIL mid reset aborted: got %0d active samples want 0", spurious); end
    check_op("after reset", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div0;
    test_overflow;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
